seven_seg_scan: RTL and testbench

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the processor wrapper and consumes its registered 32-bit `SEVENSEGHEX` word plus per-digit decimal points. It generates the digit scan, per-frame tear-free latching, leading-zero blanking and PWM brightness. All outputs are registered and active-low, and drive the FPGA pins directly.

---
 rtl/seven_seg_scan_if.sv | 23 ++
 rtl/seven_seg_scan.sv | 132 +++++++++++++
 tb/tb_seven_seg_scan.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - display value inputs and pin outputs of seven_seg_scan
interface seven_seg_scan_if #(
    parameter int N_DIGITS = 8
);
    logic [4*N_DIGITS-1:0] HEX_IN;
    logic [N_DIGITS-1:0]   DP_IN;
    logic                  BLANK_LZ;
    logic [3:0]            BRIGHT;
    logic [N_DIGITS-1:0]   ANODE;
    logic [6:0]            CATHODE;
    logic                  DP;
    logic                  FRAME_DONE;

    modport master (
        output HEX_IN, DP_IN, BLANK_LZ, BRIGHT,
        input  ANODE, CATHODE, DP, FRAME_DONE
    );

    modport slave (
        input  HEX_IN, DP_IN, BLANK_LZ, BRIGHT,
        output ANODE, CATHODE, DP, FRAME_DONE
    );
endinterface

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed 7-segment scan driver with frame-latched shadow,
// leading-zero blanking and PWM brightness; all pin outputs registered, active-low.
module seven_seg_scan #(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 4096
) (
    input  logic           CLK,
    input  logic           RESET,
    seven_seg_scan_if.slave disp
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [PW:0]   ON_STEP  = (PW+1)'(SCAN_DIV / 16);

    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] hex_sh_q;
    logic [N_DIGITS-1:0]   dp_sh_q;
    logic                  blz_sh_q;
    logic [3:0]            bright_sh_q;

    logic                  load;
    logic [N_DIGITS-1:0]   blank;
    logic                  zero_above;
    logic [3:0]            nib_cur;
    logic                  blank_cur;
    logic                  dp_cur;
    logic [PW:0]           on_lim;
    logic                  lit;
    logic [N_DIGITS-1:0]   anode_d;
    logic [6:0]            cathode_d;
    logic                  dp_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] h);
        case (h)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    assign load = (pre_q == PRE_LAST) && (idx_q == IDX_LAST);

    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // Walk from the leftmost digit down: a digit is blanked while every nibble at or above it is zero.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (hex_sh_q[4*k +: 4] == 4'h0);
            blank[k]   = blz_sh_q & zero_above & (k != 0);
        end
    end

    always_comb begin
        nib_cur   = 4'h0;
        blank_cur = 1'b0;
        dp_cur    = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (IW'(k) == idx_q) begin
                nib_cur   = hex_sh_q[4*k +: 4];
                blank_cur = blank[k];
                dp_cur    = dp_sh_q[k];
            end
        end
    end

    // pre==0 stays dark so the previous digit never bleeds into the new slot.
    always_comb begin
        on_lim    = ((PW+1)'(bright_sh_q) + (PW+1)'(1)) * ON_STEP;
        lit       = (pre_q != '0) && ({1'b0, pre_q} < on_lim) && (!blank_cur || dp_cur);
        anode_d   = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (lit && (IW'(k) == idx_q)) begin
                anode_d[k] = 1'b0;
            end
        end
        cathode_d = blank_cur ? 7'h7F : seg_decode(nib_cur);
        dp_d      = ~dp_cur;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pre_q           <= '0;
            idx_q           <= '0;
            hex_sh_q        <= '0;
            dp_sh_q         <= '0;
            blz_sh_q        <= 1'b0;
            bright_sh_q     <= 4'hF;
            disp.ANODE      <= '1;
            disp.CATHODE    <= 7'h7F;
            disp.DP         <= 1'b1;
            disp.FRAME_DONE <= 1'b0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            if (load) begin
                hex_sh_q    <= disp.HEX_IN;
                dp_sh_q     <= disp.DP_IN;
                blz_sh_q    <= disp.BLANK_LZ;
                bright_sh_q <= disp.BRIGHT;
            end
            disp.ANODE      <= anode_d;
            disp.CATHODE    <= cathode_d;
            disp.DP         <= dp_d;
            disp.FRAME_DONE <= load;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - directed bench for seven_seg_scan at SCAN_DIV=16, N_DIGITS=8
module tb_seven_seg_scan;
    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   fd_cnt;
    int   lit_cnt;

    seven_seg_scan_if #(.N_DIGITS(8)) disp();

    seven_seg_scan #(.N_DIGITS(8), .SCAN_DIV(16)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .disp  (disp)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cyc = index of the edge whose outputs are being observed, counted from reset release
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (disp.FRAME_DONE === 1'b1) begin
            fd_cnt++;
            check("fd_pos", cyc % 128, 127);
        end
        if (disp.ANODE !== 8'hFF) lit_cnt++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check_digit(input string tag, input logic [7:0] an, input logic [6:0] ca);
        check({tag, "_an"}, {24'h0, disp.ANODE}, {24'h0, an});
        check({tag, "_ca"}, {25'h0, disp.CATHODE}, {25'h0, ca});
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_an"}, {24'h0, disp.ANODE}, 32'hFF);
        check({tag, "_ca"}, {25'h0, disp.CATHODE}, 32'h7F);
        check({tag, "_dp"}, {31'h0, disp.DP}, 32'h1);
        check({tag, "_fd"}, {31'h0, disp.FRAME_DONE}, 32'h0);
    endtask

    initial begin
        RESET         = 1'b0;
        disp.HEX_IN   = 32'h12345678;
        disp.DP_IN    = 8'h00;
        disp.BLANK_LZ = 1'b0;
        disp.BRIGHT   = 4'hF;
        cyc           = -1000;
        fd_cnt        = 0;
        lit_cnt       = 0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outs("reset");

        RESET       = 1'b1;
        cyc         = -1;
        fd_cnt      = 0;
        lit_cnt     = 0;
        disp.HEX_IN = 32'h89ABCDEF;

        // frame 0: reset shadow, zeros everywhere
        run_to(0);   check("f0_dead", {24'h0, disp.ANODE}, 32'hFF);
        run_to(1);   check_digit("f0_d0", 8'hFE, 7'h40);
        run_to(113); check_digit("f0_d7", 8'h7F, 7'h40);
        run_to(127);
        check("f0_fd", {31'h0, disp.FRAME_DONE}, 32'h1);
        check("f0_lit", lit_cnt, 120);
        lit_cnt = 0;

        // frame 1: 89ABCDEF at full brightness
        run_to(129); check_digit("f1_d0", 8'hFE, 7'h0E);
        run_to(143); check("f1_pre15", {24'h0, disp.ANODE}, 32'hFE);
        run_to(144); check("f1_slot_dead", {24'h0, disp.ANODE}, 32'hFF);
        disp.HEX_IN = 32'h11111111;
        run_to(241); check_digit("f1_d7", 8'h7F, 7'h00);
        run_to(255);
        check("f1_lit", lit_cnt, 120);
        check("f1_fdcnt", fd_cnt, 2);

        // frame 2: input changes while digit 3 is shown must not tear
        run_to(309); disp.HEX_IN = 32'h22222222;
        run_to(321); check_digit("tear_d4", 8'hEF, 7'h79);
        run_to(376); check_digit("tear_d7", 8'h7F, 7'h79);
        run_to(385); check_digit("f3_d0", 8'hFE, 7'h24);
        disp.HEX_IN   = 32'h00000A05;
        disp.BLANK_LZ = 1'b1;
        disp.DP_IN    = 8'h20;
        run_to(466); check_digit("f3_d5", 8'hDF, 7'h24);
        run_to(511); lit_cnt = 0;

        // frame 4: leading-zero blanking with a lone DP on digit 5
        run_to(513); check_digit("lz_d0", 8'hFE, 7'h12);
        check("lz_d0_dp", {31'h0, disp.DP}, 32'h1);
        run_to(529); check_digit("lz_d1", 8'hFD, 7'h40);
        run_to(545); check_digit("lz_d2", 8'hFB, 7'h08);
        run_to(561); check("lz_d3", {24'h0, disp.ANODE}, 32'hFF);
        run_to(577); check("lz_d4", {24'h0, disp.ANODE}, 32'hFF);
        run_to(593); check_digit("lz_d5", 8'hDF, 7'h7F);
        check("lz_d5_dp", {31'h0, disp.DP}, 32'h0);
        run_to(609); check("lz_d6", {24'h0, disp.ANODE}, 32'hFF);
        run_to(625); check("lz_d7", {24'h0, disp.ANODE}, 32'hFF);
        disp.HEX_IN = 32'h0;
        disp.DP_IN  = 8'h00;
        run_to(639); check("lz_lit", lit_cnt, 60);
        lit_cnt = 0;

        // frame 5: all zero with blanking keeps only digit 0
        run_to(641); check_digit("lz0_d0", 8'hFE, 7'h40);
        disp.BLANK_LZ = 1'b0;
        disp.BRIGHT   = 4'd3;
        run_to(767); check("lz0_lit", lit_cnt, 15);
        lit_cnt = 0;

        // frame 6: BRIGHT=3 lights pre 1..3 only
        run_to(800); check("br3_pre0", {24'h0, disp.ANODE}, 32'hFF);
        run_to(801); check_digit("br3_pre1", 8'hFB, 7'h40);
        run_to(803); check("br3_pre3", {24'h0, disp.ANODE}, 32'hFB);
        run_to(804); check("br3_pre4", {24'h0, disp.ANODE}, 32'hFF);
        disp.BRIGHT = 4'd0;
        run_to(895); check("br3_lit", lit_cnt, 24);
        lit_cnt = 0;
        disp.BRIGHT = 4'hF;

        // frame 7: BRIGHT=0 never lights
        run_to(1023);
        check("br0_lit", lit_cnt, 0);
        check("fd_total", fd_cnt, 8);

        // reset pulse at idx=5, pre=9 of frame 8
        disp.HEX_IN = 32'h33333333;
        run_to(1112);
        RESET = 1'b0;
        tick();
        check_reset_outs("midrst");
        RESET  = 1'b1;
        cyc    = -1;
        fd_cnt = 0;
        run_to(1);   check_digit("post_d0", 8'hFE, 7'h40);
        run_to(126); check("post_nofd", fd_cnt, 0);
        run_to(127); check("post_fd", {31'h0, disp.FRAME_DONE}, 32'h1);
        run_to(129); check_digit("post_f1_d0", 8'hFE, 7'h30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
